// File: rtl/mod_exp_r1_pkg.sv
// Shared constants and state encoding
// for the modular exponentiation block.
package mod_exp_r1_pkg;

    localparam int W       = 32;
    localparam int ITERS   = 32;
    localparam int MUL_LAT = 33;

    localparam logic [5:0] LAST_IT = 6'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STEP,
        FIN
    } state_t;

endpackage

// File: rtl/mod_mul_seq.sv
// Interleaved modular multiply: result = a*b mod p.
// One issue cycle, then one multiplier bit per cycle, MSB first.
module mod_mul_seq
    import mod_exp_r1_pkg::*;
#(
    parameter int W = mod_exp_r1_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic [W-1:0] result,
    output logic         done
);

    logic [W-1:0] ar;
    logic [W-1:0] br;
    logic [W-1:0] pr;
    logic [W-1:0] r;
    logic [W-1:0] r_nxt;
    logic [W+1:0] pw;
    logic [W+1:0] t0;
    logic [W+1:0] t1;
    logic [W+1:0] t2;
    logic [5:0]   cnt;
    logic         run;

    // One iteration: 2R + a_i*B stays below 3p, so two
    // conditional subtractions bring it back under p.
    always_comb begin
        pw    = {2'b00, pr};
        t0    = {1'b0, r, 1'b0} + (ar[W-1] ? {2'b00, br} : '0);
        t1    = (t0 >= pw) ? (t0 - pw) : t0;
        t2    = (t1 >= pw) ? (t1 - pw) : t1;
        r_nxt = W'(t2);
    end

    // Operand capture, iteration sequencing and result register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ar     <= '0;
            br     <= '0;
            pr     <= '0;
            r      <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                ar  <= a;
                br  <= b;
                pr  <= p;
                r   <= '0;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                r   <= r_nxt;
                ar  <= ar << 1;
                cnt <= cnt + 6'd1;
                if (cnt == LAST_IT) begin
                    run    <= 1'b0;
                    done   <= 1'b1;
                    result <= r_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/mod_exp_r1.sv
// Right-to-left square-and-multiply g^x mod p built on two
// sequential modular multipliers, fixed latency for any operands.
module mod_exp_r1
    import mod_exp_r1_pkg::*;
#(
    parameter int W = mod_exp_r1_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st,
    input  logic [W-1:0] g,
    input  logic [W-1:0] x,
    input  logic [W-1:0] p,
    output logic [W-1:0] r1,
    output logic         done,
    output logic         busy,
    output logic         err
);

    state_t state;
    state_t nxt;

    logic [W-1:0] acc;
    logic [W-1:0] base;
    logic [W-1:0] xr;
    logic [W-1:0] gr;
    logic [W-1:0] pr;
    logic [5:0]   phase;
    logic         first;

    logic [W-1:0] acc_d;
    logic [W-1:0] base_d;
    logic [W-1:0] xr_d;
    logic [W-1:0] gr_d;
    logic [W-1:0] pr_d;
    logic [5:0]   phase_d;
    logic         first_d;

    logic         ms_go;
    logic [W-1:0] ba_in;
    logic [W-1:0] bb_in;
    logic [W-1:0] ares;
    logic [W-1:0] bres;
    logic         adone;
    logic         bdone;
    logic         to_fin_run;
    logic         to_fin_err;

    // Next state, datapath updates and multiplier launch; a finished
    // multiply is consumed on the same edge the next one is issued.
    always_comb begin
        nxt        = state;
        acc_d      = acc;
        base_d     = base;
        xr_d       = xr;
        gr_d       = gr;
        pr_d       = pr;
        phase_d    = phase;
        first_d    = 1'b0;
        ms_go      = 1'b0;
        to_fin_run = 1'b0;
        to_fin_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (st) begin
                    gr_d    = g;
                    pr_d    = p;
                    xr_d    = x;
                    phase_d = '0;
                    acc_d   = (p == W'(1)) ? '0 : W'(1);
                    if (p == '0) begin
                        nxt        = FIN;
                        to_fin_err = 1'b1;
                    end else begin
                        nxt     = LOAD;
                        first_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (first) begin
                    ms_go = 1'b1;
                end else if (bdone) begin
                    base_d = bres;
                    nxt    = STEP;
                    ms_go  = 1'b1;
                end
            end
            STEP: begin
                if (adone && bdone) begin
                    base_d = bres;
                    if (xr[0]) begin
                        acc_d = ares;
                    end
                    xr_d = xr >> 1;
                    if (phase == LAST_IT) begin
                        nxt        = FIN;
                        to_fin_run = 1'b1;
                    end else begin
                        phase_d = phase + 6'd1;
                        ms_go   = 1'b1;
                    end
                end
            end
            FIN: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
        ba_in = first ? gr : base_d;
        bb_in = first ? W'(1) : base_d;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Operand and loop registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc   <= '0;
            base  <= '0;
            xr    <= '0;
            gr    <= '0;
            pr    <= '0;
            phase <= '0;
            first <= 1'b0;
        end else begin
            acc   <= acc_d;
            base  <= base_d;
            xr    <= xr_d;
            gr    <= gr_d;
            pr    <= pr_d;
            phase <= phase_d;
            first <= first_d;
        end
    end

    // Outputs; r1 lands on the edge entering FIN so it is
    // valid in the same cycle done pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r1   <= W'(1);
            done <= 1'b0;
            busy <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= to_fin_run | to_fin_err;
            err  <= to_fin_err;
            busy <= (nxt == LOAD) || (nxt == STEP) || to_fin_run;
            if (to_fin_run) begin
                r1 <= acc_d;
            end else if (to_fin_err) begin
                r1 <= '0;
            end
        end
    end

    mod_mul_seq #(.W(W)) u_mul_acc (
        .clk    (clk),
        .rst    (rst),
        .start  (ms_go),
        .a      (acc_d),
        .b      (base_d),
        .p      (pr),
        .result (ares),
        .done   (adone)
    );

    mod_mul_seq #(.W(W)) u_mul_base (
        .clk    (clk),
        .rst    (rst),
        .start  (ms_go),
        .a      (ba_in),
        .b      (bb_in),
        .p      (pr),
        .result (bres),
        .done   (bdone)
    );

endmodule

// File: tb/tb_mod_exp_r1.sv
// Self-checking bench for mod_exp_r1: directed corner runs,
// random runs against a modular exponent model, mid-run reset.
module tb_mod_exp_r1;

    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic [31:0] g;
    logic [31:0] x;
    logic [31:0] p;
    logic [31:0] r1;
    logic        done;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    mod_exp_r1 #(.W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .st   (st),
        .g    (g),
        .x    (x),
        .p    (p),
        .r1   (r1),
        .done (done),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_exp(input logic [31:0] gg,
                                            input logic [31:0] xx,
                                            input logic [31:0] pp);
        logic [63:0] m;
        logic [63:0] r;
        logic [63:0] b;
        if (pp == 32'd0) return 32'd0;
        m = {32'd0, pp};
        r = 64'd1 % m;
        b = {32'd0, gg} % m;
        for (int i = 0; i < 32; i++) begin
            if (xx[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r[31:0];
    endfunction

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input logic [31:0] gg,
                          input logic [31:0] xx,
                          input logic [31:0] pp,
                          input bit repulse);
        int          cyc;
        int          bad;
        bit          seen;
        logic [31:0] exp_r;
        int          exp_lat;
        exp_r   = ref_exp(gg, xx, pp);
        exp_lat = (pp == 32'd0) ? 1 : 1091;
        @(negedge clk);
        g  = gg;
        x  = xx;
        p  = pp;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        g  = $urandom;
        x  = $urandom;
        p  = $urandom;
        cyc  = 1;
        bad  = 0;
        seen = 0;
        while (!seen && cyc <= 1200) begin
            if (busy !== (pp != 32'd0)) bad++;
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (repulse && cyc == 500) begin
                    st = 1'b1;
                    g  = 32'd7;
                    x  = 32'd3;
                    p  = 32'd11;
                end else begin
                    st = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("latency", seen ? 64'(cyc) : 64'hFFFF, 64'(exp_lat));
        check("r1", 64'(r1), 64'(exp_r));
        check("err", 64'(err), 64'(pp == 32'd0));
        check("busy_profile", 64'(bad), 64'd0);
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("r1_hold", 64'(r1), 64'(exp_r));
    endtask

    initial begin
        int  bad_done;
        rst = 1'b0;
        st  = 1'b0;
        g   = '0;
        x   = '0;
        p   = '0;
        repeat (3) @(negedge clk);
        check("rst_r1", 64'(r1), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_run(32'd5, 32'd6, 32'd23, 1'b0);
        do_run(32'd7, 32'd0, 32'd23, 1'b0);
        do_run(32'd9, 32'd5, 32'd1, 1'b0);
        do_run(32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 1'b0);
        do_run(32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        do_run(32'd12, 32'd34, 32'd0, 1'b0);
        do_run(32'd5, 32'd6, 32'd23, 1'b1);
        do_run(32'd100, 32'd3, 32'd7, 1'b0);
        for (int k = 0; k < 3; k++) begin
            do_run($urandom, $urandom, $urandom, 1'b0);
        end
        do_run($urandom, $urandom, 32'($urandom_range(2, 1000)), 1'b0);

        @(negedge clk);
        g  = 32'd5;
        x  = 32'd6;
        p  = 32'd23;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        bad_done = 0;
        for (int c = 1; c < 1694; c++) begin
            if (done !== 1'b0) bad_done++;
            if (c >= 601 && c <= 603) check("rst_mid_r1", 64'(r1), 64'd1);
            if (c == 600) rst = 1'b0;
            if (c == 603) begin
                rst = 1'b1;
                st  = 1'b1;
                g   = 32'd5;
                x   = 32'd6;
                p   = 32'd23;
            end else begin
                st = 1'b0;
            end
            @(negedge clk);
        end
        check("rst_mid_no_done", 64'(bad_done), 64'd0);
        check("rst_mid_done", 64'(done), 64'd1);
        check("rst_mid_r1_final", 64'(r1), 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
